instr_fetch_unit: RTL

- Front-end stage upstream of instruction decode and immediate sign-extension.
- Holds the PC and issues word fetch requests to instruction memory with a valid/ready handshake.
- Buffers returned instructions in a small in-order queue and presents {instr, pc} to decode with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution, which flush all in-flight and queued work.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_queue.sv | 66 ++++++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package riscv_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction tagged with the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Width of an occupancy counter that must be able to hold the value depth itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush and occupancy count.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal when a pop frees the head slot in the same cycle.
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage, pointers and count; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: PC generation, credit-limited memory requests, in-order
// instruction queue toward decode, and redirect handling with stale-response discard.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int CW = cnt_width(QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0] pc;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         iq_count;
  logic [CW-1:0]         aq_count;
  logic [CW:0]           credit_sum;
  logic                  iq_full;
  logic                  iq_empty;
  logic                  aq_full;
  logic                  aq_empty;
  logic                  req_fire;
  logic                  rsp_keep;
  logic                  dec_pop;
  fetch_entry_t          iq_push_entry;
  fetch_entry_t          aq_push_entry;
  fetch_entry_t          iq_head;
  fetch_entry_t          aq_head;
  logic                  unused_ok;

  // Request credit counts both in-flight requests and queued instructions so a
  // returning response always finds a free slot; rst_n gating keeps the request
  // low while reset is held even though the counters already read zero.
  always_comb begin
    credit_sum     = {1'b0, aq_count} + {1'b0, iq_count};
    imem_req_valid = rst_n && (credit_sum < (CW + 1)'(QUEUE_DEPTH)) && !redirect_valid;
    imem_req_addr  = pc;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && (discard == '0) && !redirect_valid;
    instr_valid    = !iq_empty;
    dec_pop        = instr_valid && instr_ready;
    instr_o        = iq_head.instr;
    instr_pc       = iq_head.pc;
    aq_push_entry  = '{instr: '0, pc: pc};
    iq_push_entry  = '{instr: imem_rsp_data, pc: aq_head.pc};
  end

  // Fetch PC: a redirect always wins, otherwise advance one word per accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc + DATA_WIDTH'(INSTR_BYTES);
    end
  end

  // On redirect every request still in flight after this cycle is stale; the
  // request line is held low during a redirect, so only a response this cycle
  // reduces that number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= aq_count - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (discard != '0)) begin
      discard <= discard - CW'(1);
    end
  end

  // Instruction queue toward decode; a redirect flushes it after any decode handshake that cycle.
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_instr_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rsp_keep),
    .push_entry (iq_push_entry),
    .pop        (dec_pop),
    .flush      (redirect_valid),
    .head       (iq_head),
    .full       (iq_full),
    .empty      (iq_empty),
    .count      (iq_count)
  );

  // Addresses of accepted requests in issue order; its count is the outstanding
  // request count, and it drains on every response including discarded ones.
  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_addr_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (req_fire),
    .push_entry (aq_push_entry),
    .pop        (imem_rsp_valid),
    .flush      (1'b0),
    .head       (aq_head),
    .full       (aq_full),
    .empty      (aq_empty),
    .count      (aq_count)
  );

  // Status bits that the credit rule makes redundant are collected here on purpose.
  assign unused_ok = &{1'b0, aq_head.instr, aq_full, aq_empty, iq_full};

endmodule
